if_fetch: RTL and testbench
===========================

# if_fetch

Instruction-fetch stage sitting directly downstream of the PC register and feeding the decode stage; it replaces the plain IF/ID register. It reads each 32-bit instruction from a byte-wide instruction memory in four handshaked beats and assembles it little-endian. It raises a stall request so the PC holds until the instruction is complete, then presents the instruction and its PC to decode. Taken branches flush any in-flight fetch.

## Interface
- No parameters. Widths come from the shared defines: `InstAddrBus` and `InstBus` are 32 bits, `MemByteBus` is 8 bits.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- pc  in  32  fetch address from the PC register.
- ce  in  1  fetch enable from the PC register; 0 means idle.
- branch_flag_i  in  1  taken branch this cycle; flush.
- stall  in  6  pipeline stall vector from the control block; bit1 is IF/ID, bit2 is ID.
- mem_rdata  in  8  byte returned by memory; valid when mem_ack=1.
- mem_ack  in  1  memory accepted the request and mem_rdata is valid.
- mem_req  out  1  registered byte-read request.
- mem_addr  out  32  registered byte address.
- if_pc  out  32  PC of the instruction presented to decode.
- if_inst  out  32  instruction presented to decode.
- if_valid  out  1  if_inst/if_pc hold a real instruction; 0 means bubble.
- stallreq  out  1  combinational; holds the PC register while a fetch is incomplete.

## Operation
- States:
  - IDLE: no request outstanding.
  - FETCH: beats 0..3 in progress; beat count `cnt` is 2 bits.
  - HOLD: instruction fully assembled, waiting for stall[1] to release.
- IDLE → FETCH when ce=1 and branch_flag_i=0. On that edge: mem_req<=1, mem_addr<=pc, pc_q<=pc, cnt<=0.
- FETCH, on a mem_ack beat:
  - Store the byte as buf[8·cnt+7 : 8·cnt].
  - If cnt<3: cnt<=cnt+1 and mem_addr<=mem_addr+1. The address wraps modulo 2^32.
  - If cnt=3: mem_req<=0.
    - If stall[1]=NoStop: load outputs (below) and go to IDLE.
    - If stall[1]=Stop: go to HOLD.
- mem_req and mem_addr stay stable until mem_ack. Memory may insert any number of wait cycles.
- HOLD: when stall[1]=NoStop, load outputs and go to IDLE.
- Loading outputs means: if_inst<={byte3,byte2,byte1,byte0}, if_pc<=pc_q, if_valid<=1.
- Output register rules, in the same edge, highest priority first:
  1. branch_flag_i=1 → if_valid<=0 and if_inst<=ZeroWord.
  2. stall[1]=Stop and stall[2]=NoStop → bubble: if_valid<=0 and if_inst<=ZeroWord.
  3. stall[1]=Stop and stall[2]=Stop → hold all outputs.
  4. Otherwise, a completing instruction is loaded. With no completing instruction, if_valid<=0.
- Flush (branch_flag_i=1), from any state:
  - Next state is IDLE and mem_req<=0.
  - A mem_ack in the same cycle is discarded; the memory must be read-only and side-effect-free.
  - The partial buffer and any HOLD contents are discarded.
- Misaligned pc (pc[1:0]≠0) is not checked; the four bytes are fetched from the address as given.
- stallreq = ce & ~branch_flag_i & ~complete, where complete is either:
  - FETCH, cnt=3, mem_ack=1, stall[1]=NoStop; or
  - HOLD with stall[1]=NoStop.

## Timing
- Reset values, asynchronous: state=IDLE, cnt=0, mem_req=0, mem_addr=0, pc_q=0, buf=0, if_pc=0, if_inst=0, if_valid=0.
- stallreq is 0 while in reset, because ce is 0.
- Latency with zero-wait memory:
  - 1 IDLE cycle plus 4 FETCH cycles per instruction.
  - if_valid rises on the edge ending the 4th ack.
  - The PC advances on that same edge.
- Steady-state throughput: one instruction per 5 cycles, plus memory wait cycles.
- Reset asserted mid-fetch: all state clears immediately. mem_req drops without waiting for an ack.
- ce falling mid-fetch does not abort; only reset or a flush aborts.

## Structure
- Add to defines.v:
  - `MemByteBus` 7:0
  - state encodings `IfIdle`, `IfFetch`, `IfHold` (2 bits)
  - `Flush` / `NoFlush` aliases of `Branch`
  - existing `Stop`, `NoStop`, `ZeroWord` are reused
- Single module, no sub-module. The byte assembler is small enough to stay inline.

## Test plan
- Reset mid-FETCH with cnt=2 → on reset assertion, outputs immediately equal their reset values and mem_req=0. After release with ce=1, the fetch restarts at the current pc with beat 0.
- pc=0x100, ce=1, zero-wait memory returning bytes 0x13,0x05,0x10,0x00:
  - mem_addr sequence 0x100..0x103.
  - 5 cycles after the start: if_inst=0x00100513, if_pc=0x100, if_valid=1.
  - stallreq=0 only in the final ack cycle.
- Same fetch with 2 wait cycles on every beat → mem_addr is held during the waits; completion comes 8 cycles later than zero-wait; the result is identical.
- branch_flag_i=1 on beat 2 while mem_ack=1:
  - The byte is discarded, mem_req=0 next cycle, if_valid=0 next cycle.
  - The new fetch starts from the branch target; no stale byte appears in the next if_inst.
- Final ack with stall=6'b000011 (stall[1]=Stop, stall[2]=NoStop):
  - The block enters HOLD and if_valid=0, giving a bubble to decode.
  - When stall clears, the held instruction loads with if_valid=1 and stallreq=0 for that cycle.
- pc=0xFFFFFFFE → mem_addr sequence FFFFFFFE, FFFFFFFF, 00000000, 00000001; if_pc=0xFFFFFFFE.

Source files
------------

// File: rtl/if_fetch_pkg.sv
// Shared widths, state encodings and pipeline control aliases for the
// byte-serial instruction fetch stage.
package if_fetch_pkg;

    localparam int InstAddrBusW = 32;
    localparam int InstBusW     = 32;
    localparam int MemByteBusW  = 8;

    typedef enum logic [1:0] {
        IfIdle  = 2'd0,
        IfFetch = 2'd1,
        IfHold  = 2'd2
    } if_state_e;

    localparam logic Stop      = 1'b1;
    localparam logic NoStop    = 1'b0;
    localparam logic Branch    = 1'b1;
    localparam logic NotBranch = 1'b0;
    localparam logic Flush     = Branch;
    localparam logic NoFlush   = NotBranch;

    localparam logic [InstBusW-1:0] ZeroWord = '0;

endpackage

// File: rtl/if_fetch.sv
// Instruction fetch stage: reads one 32-bit instruction as four little-endian
// byte beats, stalls the PC until complete, and presents it to decode.
module if_fetch
    import if_fetch_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [InstAddrBusW-1:0] pc,
    input  logic                    ce,
    input  logic                    branch_flag_i,
    input  logic [5:0]              stall,
    input  logic [MemByteBusW-1:0]  mem_rdata,
    input  logic                    mem_ack,
    output logic                    mem_req,
    output logic [InstAddrBusW-1:0] mem_addr,
    output logic [InstAddrBusW-1:0] if_pc,
    output logic [InstBusW-1:0]     if_inst,
    output logic                    if_valid,
    output logic                    stallreq
);

    if_state_e                    r_state;
    logic [1:0]                   r_cnt;
    logic [3:0][MemByteBusW-1:0]  r_buf;
    logic [InstAddrBusW-1:0]      r_pc_q;
    logic                         r_mem_req;
    logic [InstAddrBusW-1:0]      r_mem_addr;
    logic [InstAddrBusW-1:0]      r_if_pc;
    logic [InstBusW-1:0]          r_if_inst;
    logic                         r_if_valid;

    logic                         w_complete;
    logic [InstBusW-1:0]          w_word;
    logic                         w_unused_stall;

    // Only the IF/ID and ID stall bits matter to this stage.
    assign w_unused_stall = ^{stall[5:3], stall[0]};

    assign w_complete = ((r_state == IfFetch) && (r_cnt == 2'd3) && mem_ack && (stall[1] == NoStop))
                      || ((r_state == IfHold) && (stall[1] == NoStop));

    // On the final beat the top byte is still on the bus, not yet in the buffer.
    assign w_word = (r_state == IfHold) ? r_buf : {mem_rdata, r_buf[2], r_buf[1], r_buf[0]};

    assign stallreq = ce & ~branch_flag_i & ~w_complete;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IfIdle;
            r_cnt      <= 2'd0;
            r_buf      <= '0;
            r_pc_q     <= '0;
            r_mem_req  <= 1'b0;
            r_mem_addr <= '0;
            r_if_pc    <= '0;
            r_if_inst  <= ZeroWord;
            r_if_valid <= 1'b0;
        end else begin
            if (branch_flag_i == Flush) begin
                r_state   <= IfIdle;
                r_mem_req <= 1'b0;
            end else begin
                case (r_state)
                    IfIdle: begin
                        if (ce) begin
                            r_state    <= IfFetch;
                            r_mem_req  <= 1'b1;
                            r_mem_addr <= pc;
                            r_pc_q     <= pc;
                            r_cnt      <= 2'd0;
                        end
                    end
                    IfFetch: begin
                        if (mem_ack) begin
                            r_buf[r_cnt] <= mem_rdata;
                            if (r_cnt != 2'd3) begin
                                r_cnt      <= r_cnt + 2'd1;
                                r_mem_addr <= r_mem_addr + 32'd1;
                            end else begin
                                r_mem_req <= 1'b0;
                                r_state   <= (stall[1] == Stop) ? IfHold : IfIdle;
                            end
                        end
                    end
                    IfHold: begin
                        if (stall[1] == NoStop) begin
                            r_state <= IfIdle;
                        end
                    end
                    default: r_state <= IfIdle;
                endcase
            end

            if (branch_flag_i == Flush) begin
                r_if_valid <= 1'b0;
                r_if_inst  <= ZeroWord;
            end else if ((stall[1] == Stop) && (stall[2] == NoStop)) begin
                r_if_valid <= 1'b0;
                r_if_inst  <= ZeroWord;
            end else if ((stall[1] == Stop) && (stall[2] == Stop)) begin
                r_if_valid <= r_if_valid;
            end else if (w_complete) begin
                r_if_inst  <= w_word;
                r_if_pc    <= r_pc_q;
                r_if_valid <= 1'b1;
            end else begin
                r_if_valid <= 1'b0;
            end
        end
    end

    assign mem_req  = r_mem_req;
    assign mem_addr = r_mem_addr;
    assign if_pc    = r_if_pc;
    assign if_inst  = r_if_inst;
    assign if_valid = r_if_valid;

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: table of fetches with a scoreboard of expected
// instructions, plus hold, branch-flush and mid-fetch reset sequences.
module tb_if_fetch;

    logic        clk;
    logic        rst;
    logic [31:0] pc;
    logic        ce;
    logic        branch_flag_i;
    logic [5:0]  stall;
    logic [7:0]  mem_rdata;
    logic        mem_ack;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_valid;
    logic        stallreq;

    if_fetch dut (
        .clk           (clk),
        .rst           (rst),
        .pc            (pc),
        .ce            (ce),
        .branch_flag_i (branch_flag_i),
        .stall         (stall),
        .mem_rdata     (mem_rdata),
        .mem_ack       (mem_ack),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .if_pc         (if_pc),
        .if_inst       (if_inst),
        .if_valid      (if_valid),
        .stallreq      (stallreq)
    );

    typedef struct {
        logic [31:0] pc;
        int          waits;
        logic [31:0] inst;
        int          cycles;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] addr_q[$];
    vec_t        vecs[5];
    int          checks = 0;
    int          errors = 0;
    int          mem_waits = 0;
    int          deliveries = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        case (a)
            32'h100: return 8'h13;
            32'h101: return 8'h05;
            32'h102: return 8'h10;
            32'h103: return 8'h00;
            default: return a[7:0] ^ 8'h5A;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Memory model: fixed number of wait cycles before each ack; address must hold while waiting.
    initial begin : responder
        int          wcnt;
        logic [31:0] held;
        wcnt = 0;
        held = '0;
        mem_ack = 1'b0;
        mem_rdata = 8'h00;
        forever begin
            @(negedge clk);
            if (mem_req !== 1'b1) begin
                mem_ack = 1'b0;
                wcnt = 0;
            end else if (wcnt >= mem_waits) begin
                mem_ack = 1'b1;
                mem_rdata = mem_byte(mem_addr);
                addr_q.push_back(mem_addr);
                wcnt = 0;
            end else begin
                if (wcnt == 0) held = mem_addr;
                else chk("addr_hold", mem_addr, held);
                mem_ack = 1'b0;
                wcnt++;
            end
        end
    end

    // Scoreboard consumer: every cycle with if_valid must match the oldest expectation.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (rst === 1'b1 && if_valid === 1'b1) begin
                deliveries++;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid: got if_inst %h if_pc %h expected no instruction", if_inst, if_pc);
                end else begin
                    e = sb.pop_front();
                    chk("sb_inst", if_inst, e.inst);
                    chk("sb_pc", if_pc, e.pc);
                    $display("deliver pc=%h inst=%h", if_pc, if_inst);
                end
            end
        end
    end

    task automatic run_fetch(input logic [31:0] p, input int w, input logic [31:0] inst,
                             input int ncyc, input string nm);
        int cyc;
        int zeros;
        int zero_at;
        bit done;
        cyc = 0;
        zeros = 0;
        zero_at = -1;
        done = 1'b0;
        mem_waits = w;
        addr_q.delete();
        sb.push_back('{p, inst});
        pc = p;
        ce = 1'b1;
        #1;
        if (!stallreq) begin
            zeros++;
            zero_at = 0;
        end
        while (!done && cyc < ncyc + 20) begin
            step();
            cyc++;
            if (if_valid === 1'b1) done = 1'b1;
            else if (stallreq === 1'b0) begin
                zeros++;
                zero_at = cyc;
            end
        end
        ce = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no if_valid after %0d cycles expected one at %0d", nm, cyc, ncyc);
        end else begin
            chk({nm, "_latency"}, 32'(cyc), 32'(ncyc));
        end
        chk({nm, "_stallreq_zeros"}, 32'(zeros), 32'd1);
        chk({nm, "_stallreq_zero_at"}, 32'(zero_at), 32'(ncyc - 1));
        chk({nm, "_beats"}, 32'(addr_q.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < addr_q.size()) chk({nm, "_addr"}, addr_q[i], p + 32'(i));
        end
        $display("fetch %s pc=%h waits=%0d cycles=%0d", nm, p, w, cyc);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL global_timeout: got no finish expected finish before 200000");
        $fatal(1, "timeout");
    end

    initial begin : main
        int d0;
        vecs[0] = '{32'h0000_0100, 0, 32'h0010_0513, 5};
        vecs[1] = '{32'h0000_0100, 2, 32'h0010_0513, 13};
        vecs[2] = '{32'h0000_0200, 1, 32'h5958_5B5A, 9};
        vecs[3] = '{32'hFFFF_FFFE, 0, 32'h5B5A_A5A4, 5};
        vecs[4] = '{32'h0000_1003, 0, 32'h5C5F_5E59, 5};

        rst = 1'b1;
        pc = '0;
        ce = 1'b0;
        branch_flag_i = 1'b0;
        stall = 6'b0;
        #2 rst = 1'b0;
        step();
        step();
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_if_valid", 32'(if_valid), 32'd0);
        chk("rst_if_inst", if_inst, 32'd0);
        chk("rst_if_pc", if_pc, 32'd0);
        chk("rst_stallreq", 32'(stallreq), 32'd0);
        $display("reset state checked");
        rst = 1'b1;
        step();

        for (int i = 0; i < 5; i++) begin
            run_fetch(vecs[i].pc, vecs[i].waits, vecs[i].inst, vecs[i].cycles, $sformatf("vec%0d", i));
            step();
        end

        // Final ack under stall=000011: bubble while held, then load on release.
        mem_waits = 0;
        addr_q.delete();
        pc = 32'h100;
        ce = 1'b1;
        #1;
        repeat (4) step();
        stall = 6'b000011;
        #1;
        chk("hold_stallreq_final", 32'(stallreq), 32'd1);
        step();
        chk("hold_bubble_valid", 32'(if_valid), 32'd0);
        chk("hold_bubble_inst", if_inst, 32'd0);
        chk("hold_mem_req", 32'(mem_req), 32'd0);
        chk("hold_stallreq", 32'(stallreq), 32'd1);
        step();
        chk("hold2_valid", 32'(if_valid), 32'd0);
        d0 = deliveries;
        stall = 6'b0;
        sb.push_back('{32'h100, 32'h0010_0513});
        #1;
        chk("hold_release_stallreq", 32'(stallreq), 32'd0);
        step();
        ce = 1'b0;
        chk("hold_delivered", 32'(deliveries - d0), 32'd1);
        $display("hold sequence done");
        step();

        // Taken branch on beat 2 while that beat is being acked.
        addr_q.delete();
        pc = 32'h400;
        ce = 1'b1;
        #1;
        repeat (3) step();
        branch_flag_i = 1'b1;
        pc = 32'h200;
        #1;
        chk("br_stallreq", 32'(stallreq), 32'd0);
        step();
        branch_flag_i = 1'b0;
        chk("br_mem_req", 32'(mem_req), 32'd0);
        chk("br_if_valid", 32'(if_valid), 32'd0);
        run_fetch(32'h200, 1, 32'h5958_5B5A, 9, "br_target");
        step();

        // Asynchronous reset with the fetch at beat 2, then restart from beat 0.
        mem_waits = 0;
        pc = 32'h310;
        ce = 1'b1;
        #1;
        repeat (3) step();
        rst = 1'b0;
        ce = 1'b0;
        #1;
        chk("midrst_mem_req", 32'(mem_req), 32'd0);
        chk("midrst_mem_addr", mem_addr, 32'd0);
        chk("midrst_if_valid", 32'(if_valid), 32'd0);
        chk("midrst_if_inst", if_inst, 32'd0);
        chk("midrst_if_pc", if_pc, 32'd0);
        chk("midrst_stallreq", 32'(stallreq), 32'd0);
        step();
        rst = 1'b1;
        run_fetch(32'h310, 0, 32'h4948_4B4A, 5, "after_rst");
        step();
        step();

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
